// File: rtl/multi_alarm_ctrl.sv
// N-slot BCD alarm controller: in-place HH:MM editing, per-slot enable, ring timeout and snooze.
// Optional hourly chime is compiled in when BELL_CHIME_EN is defined.
module multi_alarm_ctrl #(
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5,
  parameter int CHIME_SECS  = 2,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  EN,
  input  logic                  SecTick,
  input  logic [3:0]            CurHouh,
  input  logic [3:0]            CurHoul,
  input  logic [3:0]            CurMinh,
  input  logic [3:0]            CurMinl,
  input  logic [3:0]            CurSech,
  input  logic [3:0]            CurSecl,
  input  logic                  SetBellMode,
  input  logic [IDX_W-1:0]      SelAlarm,
  input  logic                  SetHourKey,
  input  logic                  SetMinuteKey,
  input  logic                  ToggleKey,
  input  logic                  SnoozeKey,
  input  logic                  StopKey,
  output logic [3:0]            SelHouh,
  output logic [3:0]            SelHoul,
  output logic [3:0]            SelMinh,
  output logic [3:0]            SelMinl,
  output logic [NUM_ALARMS-1:0] AlarmEnVec,
  output logic                  Bell,
  output logic [IDX_W-1:0]      RingIdx,
  output logic                  Snoozing,
  output logic                  Chime
);

  if (NUM_ALARMS < 1 || NUM_ALARMS > 16 || RING_SECS < 1 || RING_SECS > 255 ||
      SNOOZE_MINS < 1 || SNOOZE_MINS > 99 || CHIME_SECS < 1 || CHIME_SECS > 255) begin : gBadParams
    $error("multi_alarm_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

  localparam logic [7:0]  RingLast   = 8'(RING_SECS - 1);
  localparam logic [13:0] SnoozeLoad = 14'(SNOOZE_MINS * 60);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ringIdx_q, ringIdx_d;
  logic [7:0]              ringCnt_q, ringCnt_d;
  logic [13:0]             snoozeCnt_q, snoozeCnt_d;
  logic                    bell_q, bell_d;
  logic                    snoozing_q, snoozing_d;
  logic [NUM_ALARMS-1:0]   enVec_q, enVec_d;
  logic [3:0]              hh_q [NUM_ALARMS];
  logic [3:0]              hl_q [NUM_ALARMS];
  logic [3:0]              mh_q [NUM_ALARMS];
  logic [3:0]              ml_q [NUM_ALARMS];
  logic [3:0]              hh_d [NUM_ALARMS];
  logic [3:0]              hl_d [NUM_ALARMS];
  logic [3:0]              mh_d [NUM_ALARMS];
  logic [3:0]              ml_d [NUM_ALARMS];

  logic [NUM_ALARMS-1:0]   matchVec;
  logic [NUM_ALARMS-1:0]   selHit;
  logic                    matchAny;
  logic [IDX_W-1:0]        winner;
  logic                    killActive;

  function automatic logic [7:0] incMin(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones == 4'd9) r = (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
    else              r = {tens, ones + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] incHour(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (tens == 4'd2 && ones == 4'd3) r = 8'h00;
    else if (ones == 4'd9)            r = {tens + 4'd1, 4'd0};
    else                              r = {tens, ones + 4'd1};
    return r;
  endfunction

  // Slot match at the top of a minute; lowest-numbered matching slot wins.
  always_comb begin
    matchAny = 1'b0;
    matchVec = '0;
    selHit   = '0;
    winner   = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      matchVec[i] = enVec_q[i] && SecTick && CurSech == 4'd0 && CurSecl == 4'd0 &&
                    hh_q[i] == CurHouh && hl_q[i] == CurHoul &&
                    mh_q[i] == CurMinh && ml_q[i] == CurMinl;
      selHit[i]   = (SelAlarm == IDX_W'(i));
    end
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (matchVec[i]) winner = IDX_W'(i);
    end
    matchAny = EN && !SetBellMode && (|matchVec);
  end

  always_comb begin
    SelHouh = '0;
    SelHoul = '0;
    SelMinh = '0;
    SelMinl = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (selHit[i]) begin
        SelHouh = hh_q[i];
        SelHoul = hl_q[i];
        SelMinh = mh_q[i];
        SelMinl = ml_q[i];
      end
    end
  end

  // An out-of-range SelAlarm hits no slot, so its keys fall through untouched.
  always_comb begin
    hh_d       = hh_q;
    hl_d       = hl_q;
    mh_d       = mh_q;
    ml_d       = ml_q;
    enVec_d    = enVec_q;
    killActive = 1'b0;
    if (EN) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (selHit[i]) begin
          if (SetBellMode && SetHourKey)   {hh_d[i], hl_d[i]} = incHour(hh_q[i], hl_q[i]);
          if (SetBellMode && SetMinuteKey) {mh_d[i], ml_d[i]} = incMin(mh_q[i], ml_q[i]);
          if (ToggleKey) begin
            enVec_d[i] = ~enVec_q[i];
            if (enVec_q[i] && state_q != IDLE && ringIdx_q == IDX_W'(i)) killActive = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ringIdx_d   = ringIdx_q;
    ringCnt_d   = ringCnt_q;
    snoozeCnt_d = snoozeCnt_q;
    if (EN) begin
      if (SetBellMode || killActive) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (matchAny) begin
              state_d   = RING;
              ringIdx_d = winner;
              ringCnt_d = '0;
            end
          end
          RING: begin
            if (StopKey) begin
              state_d = IDLE;
            end else if (SnoozeKey) begin
              state_d     = SNOOZE;
              snoozeCnt_d = SnoozeLoad;
            end else if (SecTick) begin
              if (ringCnt_q == RingLast) begin
                state_d   = IDLE;
                ringCnt_d = '0;
              end else begin
                ringCnt_d = ringCnt_q + 8'd1;
              end
            end
          end
          SNOOZE: begin
            if (StopKey) begin
              state_d = IDLE;
            end else if (matchAny) begin
              state_d   = RING;
              ringIdx_d = winner;
              ringCnt_d = '0;
            end else if (SecTick) begin
              if (snoozeCnt_q <= 14'd1) begin
                state_d     = RING;
                ringCnt_d   = '0;
                snoozeCnt_d = '0;
              end else begin
                snoozeCnt_d = snoozeCnt_q - 14'd1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    bell_d     = (state_d == RING);
    snoozing_d = (state_d == SNOOZE);
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q     <= IDLE;
      ringIdx_q   <= '0;
      ringCnt_q   <= '0;
      snoozeCnt_q <= '0;
      bell_q      <= 1'b0;
      snoozing_q  <= 1'b0;
      enVec_q     <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hh_q[i] <= '0;
        hl_q[i] <= '0;
        mh_q[i] <= '0;
        ml_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ringIdx_q   <= ringIdx_d;
      ringCnt_q   <= ringCnt_d;
      snoozeCnt_q <= snoozeCnt_d;
      bell_q      <= bell_d;
      snoozing_q  <= snoozing_d;
      enVec_q     <= enVec_d;
      hh_q        <= hh_d;
      hl_q        <= hl_d;
      mh_q        <= mh_d;
      ml_q        <= ml_d;
    end
  end

`ifdef BELL_CHIME_EN
  logic       chime_q, chime_d;
  logic [7:0] chimeCnt_q, chimeCnt_d;
  logic       topOfHour;

  assign topOfHour = CurMinh == 4'd0 && CurMinl == 4'd0 && CurSech == 4'd0 && CurSecl == 4'd0;

  // Any alarm activity kills the chime; it only starts from a quiet IDLE.
  always_comb begin
    chime_d    = chime_q;
    chimeCnt_d = chimeCnt_q;
    if (EN) begin
      if (state_d != IDLE) begin
        chime_d    = 1'b0;
        chimeCnt_d = '0;
      end else if (state_q == IDLE && !SetBellMode && SecTick && topOfHour) begin
        chime_d    = 1'b1;
        chimeCnt_d = 8'(CHIME_SECS);
      end else if (chime_q && SecTick) begin
        if (chimeCnt_q <= 8'd1) begin
          chime_d    = 1'b0;
          chimeCnt_d = '0;
        end else begin
          chimeCnt_d = chimeCnt_q - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      chime_q    <= 1'b0;
      chimeCnt_q <= '0;
    end else begin
      chime_q    <= chime_d;
      chimeCnt_q <= chimeCnt_d;
    end
  end

  assign Chime = chime_q;
`else
  assign Chime = 1'b0;
`endif

  assign AlarmEnVec = enVec_q;
  assign Bell       = bell_q;
  assign RingIdx    = ringIdx_q;
  assign Snoozing   = snoozing_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl built with five slots so an out-of-range SelAlarm exists.
// Chime expectations follow BELL_CHIME_EN.
module tb_multi_alarm_ctrl;

  localparam int NumAlarms = 5;
  localparam int IdxW      = 3;

  logic CP = 1'b0, CR = 1'b0, EN = 1'b0, SecTick = 1'b0;
  logic [3:0] CurHouh = '0, CurHoul = '0, CurMinh = '0, CurMinl = '0, CurSech = '0, CurSecl = '0;
  logic SetBellMode = 1'b0;
  logic [IdxW-1:0] SelAlarm = '0;
  logic SetHourKey = 1'b0, SetMinuteKey = 1'b0, ToggleKey = 1'b0, SnoozeKey = 1'b0, StopKey = 1'b0;
  logic [3:0] SelHouh, SelHoul, SelMinh, SelMinl;
  logic [NumAlarms-1:0] AlarmEnVec;
  logic Bell, Snoozing, Chime;
  logic [IdxW-1:0] RingIdx;

  int checks = 0;
  int failures = 0;

`ifdef BELL_CHIME_EN
  localparam logic ChimeOn = 1'b1;
`else
  localparam logic ChimeOn = 1'b0;
`endif

  multi_alarm_ctrl #(.NUM_ALARMS(NumAlarms)) dut (
    .CP(CP), .CR(CR), .EN(EN), .SecTick(SecTick),
    .CurHouh(CurHouh), .CurHoul(CurHoul), .CurMinh(CurMinh),
    .CurMinl(CurMinl), .CurSech(CurSech), .CurSecl(CurSecl),
    .SetBellMode(SetBellMode), .SelAlarm(SelAlarm),
    .SetHourKey(SetHourKey), .SetMinuteKey(SetMinuteKey), .ToggleKey(ToggleKey),
    .SnoozeKey(SnoozeKey), .StopKey(StopKey),
    .SelHouh(SelHouh), .SelHoul(SelHoul), .SelMinh(SelMinh), .SelMinl(SelMinl),
    .AlarmEnVec(AlarmEnVec), .Bell(Bell), .RingIdx(RingIdx),
    .Snoozing(Snoozing), .Chime(Chime)
  );

  always #5 CP = ~CP;

  task automatic idle(input int n);
    repeat (n) begin @(posedge CP); #1; end
  endtask

  task automatic setTime(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    {CurHouh, CurHoul} = h;
    {CurMinh, CurMinl} = m;
    {CurSech, CurSecl} = s;
  endtask

  task automatic applyStimulus(input logic hk, input logic mk, input logic tk,
                               input logic sk, input logic stk);
    SetHourKey = hk; SetMinuteKey = mk; ToggleKey = tk; SnoozeKey = sk; StopKey = stk;
    @(posedge CP); #1;
    SetHourKey = 0; SetMinuteKey = 0; ToggleKey = 0; SnoozeKey = 0; StopKey = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      SecTick = 1'b1;
      @(posedge CP); #1;
      SecTick = 1'b0;
    end
  endtask

  task automatic programSlot(input logic [IdxW-1:0] idx, input int hrs, input int mins, input logic en);
    SetBellMode = 1'b1;
    SelAlarm = idx;
    repeat (hrs) applyStimulus(1, 0, 0, 0, 0);
    repeat (mins) applyStimulus(0, 1, 0, 0, 0);
    if (en) applyStimulus(0, 0, 1, 0, 0);
    SetBellMode = 1'b0;
  endtask

  task automatic test_reset;
    CR = 1'b1;
    idle(2);
    CR = 1'b0;
    EN = 1'b1;
    idle(1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL reset_bell: got %b want 0", Bell); end
    checks++; if (Snoozing !== 1'b0) begin failures++; $display("[TB] FAIL reset_snoozing: got %b want 0", Snoozing); end
    checks++; if (RingIdx !== 3'd0) begin failures++; $display("[TB] FAIL reset_ringidx: got %0d want 0", RingIdx); end
    checks++; if (AlarmEnVec !== 5'b00000) begin failures++; $display("[TB] FAIL reset_envec: got %b want 00000", AlarmEnVec); end
    checks++; if (Chime !== 1'b0) begin failures++; $display("[TB] FAIL reset_chime: got %b want 0", Chime); end
    checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h0000) begin failures++;
      $display("[TB] FAIL reset_slot0: got %h want 0000", {SelHouh, SelHoul, SelMinh, SelMinl}); end
  endtask

  task automatic test_edit;
    programSlot(1, 7, 30, 1);
    SelAlarm = 3'd1;
    #1;
    checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h0730) begin failures++;
      $display("[TB] FAIL edit_slot1: got %h want 0730", {SelHouh, SelHoul, SelMinh, SelMinl}); end
    checks++; if (AlarmEnVec !== 5'b00010) begin failures++; $display("[TB] FAIL edit_envec: got %b want 00010", AlarmEnVec); end
  endtask

  task automatic test_ring_basic;
    setTime(8'h07, 8'h29, 8'h59); ticks(1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL ring_early: got %b want 0", Bell); end
    setTime(8'h07, 8'h30, 8'h00); ticks(1);
    checks++; if (Bell !== 1'b1) begin failures++; $display("[TB] FAIL ring_start: got %b want 1", Bell); end
    checks++; if (RingIdx !== 3'd1) begin failures++; $display("[TB] FAIL ring_idx: got %0d want 1", RingIdx); end
    setTime(8'h07, 8'h30, 8'h01); ticks(59);
    checks++; if (Bell !== 1'b1) begin failures++; $display("[TB] FAIL ring_tick59: got %b want 1", Bell); end
    ticks(1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL ring_timeout: got %b want 0", Bell); end
  endtask

  task automatic test_snooze;
    setTime(8'h07, 8'h30, 8'h00); ticks(1);
    setTime(8'h07, 8'h30, 8'h01);
    applyStimulus(0, 0, 0, 1, 0);
    checks++; if ({Bell, Snoozing} !== 2'b01) begin failures++; $display("[TB] FAIL snooze_enter: bell,snz got %b want 01", {Bell, Snoozing}); end
    ticks(299);
    checks++; if ({Bell, Snoozing} !== 2'b01) begin failures++; $display("[TB] FAIL snooze_tick299: bell,snz got %b want 01", {Bell, Snoozing}); end
    ticks(1);
    checks++; if ({Bell, Snoozing} !== 2'b10) begin failures++; $display("[TB] FAIL snooze_expire: bell,snz got %b want 10", {Bell, Snoozing}); end
    checks++; if (RingIdx !== 3'd1) begin failures++; $display("[TB] FAIL snooze_idx: got %0d want 1", RingIdx); end
    applyStimulus(0, 0, 0, 0, 1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL snooze_stop: got %b want 0", Bell); end
  endtask

  task automatic test_priority;
    programSlot(0, 12, 0, 1);
    programSlot(2, 12, 0, 1);
    setTime(8'h12, 8'h00, 8'h00); ticks(1);
    checks++; if (Bell !== 1'b1 || RingIdx !== 3'd0) begin failures++;
      $display("[TB] FAIL prio_winner: bell %b idx %0d want bell 1 idx 0", Bell, RingIdx); end
    setTime(8'h12, 8'h00, 8'h01);
    applyStimulus(0, 0, 0, 1, 1);
    checks++; if ({Bell, Snoozing} !== 2'b00) begin failures++; $display("[TB] FAIL stop_wins: bell,snz got %b want 00", {Bell, Snoozing}); end
    ticks(1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL stop_stays_idle: got %b want 0", Bell); end
  endtask

  task automatic test_snooze_replace;
    setTime(8'h12, 8'h00, 8'h00); ticks(1);
    setTime(8'h12, 8'h00, 8'h01);
    applyStimulus(0, 0, 0, 1, 0);
    checks++; if (Snoozing !== 1'b1 || RingIdx !== 3'd0) begin failures++;
      $display("[TB] FAIL replace_snooze: snz %b idx %0d want snz 1 idx 0", Snoozing, RingIdx); end
    setTime(8'h07, 8'h30, 8'h00); ticks(1);
    checks++; if ({Bell, Snoozing} !== 2'b10 || RingIdx !== 3'd1) begin failures++;
      $display("[TB] FAIL replace_ring: bell,snz %b idx %0d want 10 idx 1", {Bell, Snoozing}, RingIdx); end
    setTime(8'h07, 8'h30, 8'h01);
    SelAlarm = 3'd1;
    applyStimulus(0, 0, 1, 0, 0);
    checks++; if (Bell !== 1'b0 || AlarmEnVec !== 5'b00101) begin failures++;
      $display("[TB] FAIL disable_active: bell %b en %b want bell 0 en 00101", Bell, AlarmEnVec); end
    applyStimulus(0, 0, 1, 0, 0);
    checks++; if (AlarmEnVec !== 5'b00111) begin failures++; $display("[TB] FAIL reenable: got %b want 00111", AlarmEnVec); end
  endtask

  task automatic test_edit_abort;
    setTime(8'h07, 8'h30, 8'h00); ticks(1);
    setTime(8'h07, 8'h30, 8'h01);
    SetBellMode = 1'b1;
    idle(1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL editmode_abort: got %b want 0", Bell); end
    SetBellMode = 1'b0;
  endtask

  task automatic test_edit_wrap;
    programSlot(3, 23, 59, 0);
    SelAlarm = 3'd3; #1;
    checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h2359) begin failures++;
      $display("[TB] FAIL wrap_setup: got %h want 2359", {SelHouh, SelHoul, SelMinh, SelMinl}); end
    SetBellMode = 1'b1;
    applyStimulus(1, 1, 0, 0, 0);
    checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h0000) begin failures++;
      $display("[TB] FAIL wrap_both: got %h want 0000", {SelHouh, SelHoul, SelMinh, SelMinl}); end
    repeat (59) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h0000) begin failures++;
      $display("[TB] FAIL min_no_carry: got %h want 0000", {SelHouh, SelHoul, SelMinh, SelMinl}); end
    SelAlarm = 3'd5;
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checks++; if (AlarmEnVec !== 5'b00111) begin failures++; $display("[TB] FAIL oob_toggle: got %b want 00111", AlarmEnVec); end
    SelAlarm = 3'd4; #1;
    checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h0000) begin failures++;
      $display("[TB] FAIL oob_slot4: got %h want 0000", {SelHouh, SelHoul, SelMinh, SelMinl}); end
    SelAlarm = 3'd1; #1;
    checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h0730) begin failures++;
      $display("[TB] FAIL oob_slot1: got %h want 0730", {SelHouh, SelHoul, SelMinh, SelMinl}); end
    SetBellMode = 1'b0;
  endtask

  task automatic test_enable_freeze;
    setTime(8'h07, 8'h30, 8'h00); ticks(1);
    EN = 1'b0;
    setTime(8'h07, 8'h30, 8'h01);
    applyStimulus(0, 0, 0, 0, 1);
    ticks(70);
    checks++; if (Bell !== 1'b1 || RingIdx !== 3'd1) begin failures++;
      $display("[TB] FAIL en_freeze_ring: bell %b idx %0d want bell 1 idx 1", Bell, RingIdx); end
    EN = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL en_stop: got %b want 0", Bell); end
    EN = 1'b0;
    setTime(8'h07, 8'h30, 8'h00); ticks(1);
    checks++; if (Bell !== 1'b0) begin failures++; $display("[TB] FAIL en_no_match: got %b want 0", Bell); end
    SelAlarm = 3'd0;
    applyStimulus(0, 0, 1, 0, 0);
    checks++; if (AlarmEnVec !== 5'b00111) begin failures++; $display("[TB] FAIL en_no_toggle: got %b want 00111", AlarmEnVec); end
    setTime(8'h10, 8'h15, 8'h00);
    EN = 1'b1;
  endtask

  task automatic test_chime;
    setTime(8'h09, 8'h00, 8'h00); ticks(1);
    checks++; if (Chime !== ChimeOn || Bell !== 1'b0) begin failures++;
      $display("[TB] FAIL chime_start: chime %b bell %b want chime %b bell 0", Chime, Bell, ChimeOn); end
    setTime(8'h09, 8'h00, 8'h01); ticks(1);
    checks++; if (Chime !== ChimeOn) begin failures++; $display("[TB] FAIL chime_tick1: got %b want %b", Chime, ChimeOn); end
    setTime(8'h09, 8'h00, 8'h02); ticks(1);
    checks++; if (Chime !== 1'b0) begin failures++; $display("[TB] FAIL chime_end: got %b want 0", Chime); end
  endtask

  task automatic test_reset_midring;
    setTime(8'h07, 8'h30, 8'h00); ticks(1);
    checks++; if (Bell !== 1'b1) begin failures++; $display("[TB] FAIL midring_setup: got %b want 1", Bell); end
    setTime(8'h07, 8'h30, 8'h01);
    #2 CR = 1'b1;
    #1;
    checks++; if (Bell !== 1'b0 || RingIdx !== 3'd0) begin failures++;
      $display("[TB] FAIL midring_async: bell %b idx %0d want bell 0 idx 0", Bell, RingIdx); end
    @(posedge CP); #1;
    CR = 1'b0;
    checks++; if (AlarmEnVec !== 5'b00000) begin failures++; $display("[TB] FAIL midring_envec: got %b want 00000", AlarmEnVec); end
    for (int i = 0; i < NumAlarms; i++) begin
      SelAlarm = 3'(i); #1;
      checks++; if ({SelHouh, SelHoul, SelMinh, SelMinl} !== 16'h0000) begin failures++;
        $display("[TB] FAIL midring_slot%0d: got %h want 0000", i, {SelHouh, SelHoul, SelMinh, SelMinl}); end
    end
  endtask

  initial begin
    test_reset;
    test_edit;
    test_ring_basic;
    test_snooze;
    test_priority;
    test_snooze_replace;
    test_edit_abort;
    test_edit_wrap;
    test_enable_freeze;
    test_chime;
    test_reset_midring;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
